uart_phy: RTL and testbench
===========================

# uart_phy

Serial-line physical layer for the Wishbone UART. Converts the board's asynchronous RX pin into byte strobes (`o_rx_data`/`o_rx_stb`), which feed the buffered Wishbone UART's `i_rx_data`/`i_rx_stb`. Serializes bytes handed over on `i_tx_data`/`i_tx_stb` onto the TX pin, reporting `o_tx_busy` back to the UART's `i_tx_busy`. Frame format is fixed 8N1, LSB first, line idle high.

## Interface
- `I_CLOCK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate. Derived `CLKS_PER_BIT = I_CLOCK_FREQ / BAUD_RATE` (integer divide; 434 at defaults).

- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_uart_rx`  in  1  asynchronous serial input pin.
- `o_uart_tx`  out  1  serial output pin, registered.
- `o_rx_data`  out  8  last received byte; valid while `o_rx_stb`=1, held afterwards.
- `o_rx_stb`  out  1  one-cycle pulse per good frame.
- `o_rx_frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `i_tx_data`  in  8  byte to send; sampled on the accepted strobe.
- `i_tx_stb`  in  1  send request; accepted only when `o_tx_busy`=0.
- `o_tx_busy`  out  1  registered; high while a frame is in flight.

## Operation
- Reset values: `o_uart_tx`=1, `o_tx_busy`=0, `o_rx_stb`=0, `o_rx_frame_err`=0, `o_rx_data`=0. Both FSMs go to IDLE. RX synchronizer flops reset to 1.
- Bit counter width is `$clog2(CLKS_PER_BIT+1)`. Bit index is 4 bits.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE: on `i_tx_stb` && !`o_tx_busy`, latch `i_tx_data` into the shift register, set busy, drive 0, and go to START.
  - Each state lasts exactly `CLKS_PER_BIT` cycles.
  - DATA shifts out bit0 to bit7.
  - STOP drives 1. At its end, busy clears and the FSM returns to IDLE.
  - `i_tx_stb` while busy is ignored and does not queue.
- RX path: `i_uart_rx` passes through a 2-flop synchronizer. RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when the synchronized line is 0, load counter with `CLKS_PER_BIT/2` and go to START.
  - START: at mid-bit, a sample of 1 is a glitch and returns to IDLE with no output. A sample of 0 goes to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, shifting in LSB first, 8 samples.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - Sample 1: load `o_rx_data` and pulse `o_rx_stb`, then go to IDLE.
    - Sample 0: pulse `o_rx_frame_err`, leave `o_rx_data` unchanged, no `o_rx_stb`, go to BREAK.
  - BREAK: wait for the synchronized line to return to 1, then go to IDLE.
- RX and TX are fully independent; simultaneous activity is legal, including external loopback.
- Reset mid-frame aborts immediately. A partial TX frame is truncated (line forced to 1). A partial RX byte is discarded.

## Timing
- TX: accepting strobe at cycle N puts the start bit on `o_uart_tx` at N+1 and sets `o_tx_busy` at N+1.
  - Busy stays high for exactly `10*CLKS_PER_BIT` cycles.
  - A new strobe is accepted on the first cycle busy reads 0.
- The Wishbone UART holds its strobe for one cycle; registered busy at N+1 prevents double-send.
- RX: `o_rx_stb` rises 2 (sync) + `CLKS_PER_BIT/2` + `9*CLKS_PER_BIT` cycles after the pin falling edge, ±1 cycle.
- `o_rx_stb` and `o_rx_frame_err` are each exactly one cycle wide and never assert together.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each RX sample (start, data, stop) is the 2-of-3 majority of synchronized-line values at counter positions mid-1, mid, mid+1.
  - The decision is taken at mid+1; `o_rx_stb` latency grows by 1 cycle.
- Not defined: a single sample at mid-bit. No extra flops.

## Test plan
- TX 0x55 at defaults -> `o_uart_tx` is 0,1,0,1,0,1,0,1,0,1 with each level held 434 cycles; `o_tx_busy` high for 4340 cycles; a second `i_tx_stb` mid-frame is ignored (no second frame).
- Drive RX frame 0xA3 on `i_uart_rx` -> single `o_rx_stb` with `o_rx_data`=0xA3, `o_rx_frame_err` never asserts.
- Low glitch of 100 cycles on idle `i_uart_rx` -> no `o_rx_stb`, no `o_rx_frame_err`, FSM back in IDLE; following frame 0x0F is received correctly.
- Frame 0x7E with stop bit 0, line held low 2000 cycles, then idle, then frame 0x3C -> one `o_rx_frame_err` pulse, no stb for 0x7E, then `o_rx_stb` with 0x3C.
- Assert `i_reset` at bit 4 of a TX frame -> next cycle `o_uart_tx`=1 and `o_tx_busy`=0; a new strobe of 0x81 sends a full, correct frame.
- With `UART_RX_MAJORITY_EN`: invert one cycle exactly at mid-bit of data bit 2 in frame 0x00 -> `o_rx_data`=0x00. Without the macro, the same stimulus yields 0x04.

Source files
------------

// File: rtl/uart_phy.sv
// 8N1 serial PHY: TX serializer and RX deserializer with a 2-flop input synchronizer.
// Optional define UART_RX_MAJORITY_EN: 2-of-3 majority RX sampling around mid-bit.
//
// state    | meaning
// TX_IDLE  | line high, waiting for an accepted strobe
// TX_START | driving the start bit (0)
// TX_DATA  | shifting out data bits, LSB first
// TX_STOP  | driving the stop bit (1); busy drops at the end
// RX_IDLE  | waiting for the synchronized line to fall
// RX_START | counting to mid start bit; a high sample is a glitch
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_STOP  | sampling the stop bit; good frame or framing error
// RX_BREAK | line stuck low after a framing error; wait for idle
module uart_phy #(
   parameter int I_CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE    = 115200
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_uart_rx,
   output logic       o_uart_tx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_stb,
   output logic       o_rx_frame_err,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_stb,
   output logic       o_tx_busy
);

   localparam int CLKS_PER_BIT = I_CLOCK_FREQ / BAUD_RATE;
   localparam int CW           = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   // terminal count lands one cycle past mid so all three samples are in hand
   localparam logic [CW-1:0] MID_LOAD = CW'(CLKS_PER_BIT / 2 + 1);
`else
   localparam logic [CW-1:0] MID_LOAD = CW'(CLKS_PER_BIT / 2);
`endif

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

   tx_state_t     tx_state, tx_state_nx;
   logic [CW-1:0] tx_cnt, tx_cnt_nx;
   logic [7:0]    tx_shift, tx_shift_nx;
   logic [3:0]    tx_idx, tx_idx_nx;
   logic          tx_line, tx_line_nx;
   logic          tx_busy, tx_busy_nx;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_shift <= '0;
         tx_idx   <= '0;
         tx_line  <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_shift <= tx_shift_nx;
         tx_idx   <= tx_idx_nx;
         tx_line  <= tx_line_nx;
         tx_busy  <= tx_busy_nx;
      end
   end

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = (tx_cnt != '0) ? tx_cnt - 1'b1 : tx_cnt;
      tx_shift_nx = tx_shift;
      tx_idx_nx   = tx_idx;
      tx_line_nx  = tx_line;
      tx_busy_nx  = tx_busy;
      case (tx_state)
         TX_IDLE: begin
            if (i_tx_stb && !tx_busy) begin
               tx_shift_nx = i_tx_data;
               tx_busy_nx  = 1'b1;
               tx_line_nx  = 1'b0;
               tx_cnt_nx   = BIT_LOAD;
               tx_state_nx = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == '0) begin
               tx_line_nx  = tx_shift[0];
               tx_cnt_nx   = BIT_LOAD;
               tx_idx_nx   = '0;
               tx_state_nx = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt == '0) begin
               tx_cnt_nx = BIT_LOAD;
               if (tx_idx == 4'd7) begin
                  tx_line_nx  = 1'b1;
                  tx_state_nx = TX_STOP;
               end else begin
                  tx_shift_nx = {1'b0, tx_shift[7:1]};
                  tx_line_nx  = tx_shift[1];
                  tx_idx_nx   = tx_idx + 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tx_cnt == '0) begin
               tx_busy_nx  = 1'b0;
               tx_state_nx = TX_IDLE;
            end
         end
         default: tx_state_nx = TX_IDLE;
      endcase
   end

   assign o_uart_tx = tx_line;
   assign o_tx_busy = tx_busy;

   logic [1:0] rx_sync;
   logic       rx_s;
   logic       rx_sample;

   always_ff @(posedge i_clk) begin
      if (i_reset) rx_sync <= 2'b11;
      else         rx_sync <= {rx_sync[0], i_uart_rx};
   end
   assign rx_s = rx_sync[1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] rx_hist;
   always_ff @(posedge i_clk) begin
      if (i_reset) rx_hist <= 2'b11;
      else         rx_hist <= {rx_hist[0], rx_s};
   end
   assign rx_sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
   assign rx_sample = rx_s;
`endif

   rx_state_t     rx_state, rx_state_nx;
   logic [CW-1:0] rx_cnt, rx_cnt_nx;
   logic [7:0]    rx_shift, rx_shift_nx;
   logic [3:0]    rx_idx, rx_idx_nx;
   logic [7:0]    rx_data, rx_data_nx;
   logic          rx_stb, rx_stb_nx;
   logic          rx_err, rx_err_nx;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_shift <= '0;
         rx_idx   <= '0;
         rx_data  <= '0;
         rx_stb   <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         rx_shift <= rx_shift_nx;
         rx_idx   <= rx_idx_nx;
         rx_data  <= rx_data_nx;
         rx_stb   <= rx_stb_nx;
         rx_err   <= rx_err_nx;
      end
   end

   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = (rx_cnt != '0) ? rx_cnt - 1'b1 : rx_cnt;
      rx_shift_nx = rx_shift;
      rx_idx_nx   = rx_idx;
      rx_data_nx  = rx_data;
      rx_stb_nx   = 1'b0;
      rx_err_nx   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_cnt_nx   = MID_LOAD;
               rx_state_nx = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == '0) begin
               if (rx_sample) begin
                  rx_state_nx = RX_IDLE;
               end else begin
                  rx_cnt_nx   = BIT_LOAD;
                  rx_idx_nx   = '0;
                  rx_state_nx = RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (rx_cnt == '0) begin
               rx_shift_nx = {rx_sample, rx_shift[7:1]};
               rx_cnt_nx   = BIT_LOAD;
               if (rx_idx == 4'd7) rx_state_nx = RX_STOP;
               else                rx_idx_nx   = rx_idx + 4'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == '0) begin
               if (rx_sample) begin
                  rx_data_nx  = rx_shift;
                  rx_stb_nx   = 1'b1;
                  rx_state_nx = RX_IDLE;
               end else begin
                  rx_err_nx   = 1'b1;
                  rx_state_nx = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            if (rx_s) rx_state_nx = RX_IDLE;
         end
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   assign o_rx_data      = rx_data;
   assign o_rx_stb       = rx_stb;
   assign o_rx_frame_err = rx_err;

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy: table-driven RX frames plus hand sequences
// for TX framing, glitch rejection, framing error/break and reset mid-frame.
module tb_uart_phy;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 115200;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int H        = CPB / 2;
   localparam int GLITCH_IDX = H + 1 + 3 * CPB;
`ifdef UART_RX_MAJORITY_EN
   localparam int         MAJ        = 1;
   localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
   localparam int         MAJ        = 0;
   localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
   localparam int LAT_NOM = 2 + H + 9 * CPB;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_uart_rx;
   logic       o_uart_tx;
   logic [7:0] o_rx_data;
   logic       o_rx_stb;
   logic       o_rx_frame_err;
   logic [7:0] i_tx_data;
   logic       i_tx_stb;
   logic       o_tx_busy;

   uart_phy #(.I_CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_uart_rx     (i_uart_rx),
      .o_uart_tx     (o_uart_tx),
      .o_rx_data     (o_rx_data),
      .o_rx_stb      (o_rx_stb),
      .o_rx_frame_err(o_rx_frame_err),
      .i_tx_data     (i_tx_data),
      .i_tx_stb      (i_tx_stb),
      .o_tx_busy     (o_tx_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t_fall = 0;
   int stb_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0, stb_lat = 0;
   logic [7:0] stb_data = 8'h00;
   logic prev_stb = 1'b0, prev_err = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_rx_stb) begin
         stb_cnt  <= stb_cnt + 1;
         stb_data <= o_rx_data;
         stb_lat  <= cyc - t_fall - 1;
      end
      if (o_rx_frame_err) err_cnt <= err_cnt + 1;
      if (o_rx_stb && o_rx_frame_err) both_cnt <= both_cnt + 1;
      if ((o_rx_stb && prev_stb) || (o_rx_frame_err && prev_err)) wide_cnt <= wide_cnt + 1;
      prev_stb <= o_rx_stb;
      prev_err <= o_rx_frame_err;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Pin value index i is captured by the i-th posedge after the fall.
   task automatic rx_frame(input logic [7:0] d, input logic stop, input int glitch_idx,
                           input int tail_low);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      @(negedge i_clk);
      t_fall = cyc;
      for (int i = 0; i < 10 * CPB; i++) begin
         i_uart_rx = fr[i / CPB] ^ (i == glitch_idx);
         @(negedge i_clk);
      end
      if (tail_low > 0) begin
         i_uart_rx = 1'b0;
         repeat (tail_low) @(negedge i_clk);
      end
      i_uart_rx = 1'b1;
   endtask

   task automatic rx_expect(input logic [7:0] d, input int glitch_idx, input logic [7:0] exp);
      int s0, e0, lat_ok;
      s0 = stb_cnt;
      e0 = err_cnt;
      rx_frame(d, 1'b1, glitch_idx, 0);
      repeat (CPB) @(negedge i_clk);
      check("rx_stb_count", stb_cnt - s0, 1);
      check("rx_err_count", err_cnt - e0, 0);
      check("rx_data", int'(stb_data), int'(exp));
      lat_ok = (stb_lat >= LAT_NOM - 1 && stb_lat <= LAT_NOM + 1 + MAJ) ? 1 : 0;
      if (lat_ok == 0) $display("rx latency observed %0d cycles", stb_lat);
      check("rx_latency_in_window", lat_ok, 1);
   endtask

   task automatic tx_frame(input logic [7:0] d, input bit inject);
      logic [9:0] fr;
      int bad[10];
      int busy_lo, extra;
      fr = {1'b1, d, 1'b0};
      busy_lo = 0;
      extra = 0;
      for (int b = 0; b < 10; b++) bad[b] = 0;
      @(negedge i_clk);
      i_tx_data = d;
      i_tx_stb  = 1'b1;
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge i_clk);
         if (i == 0) i_tx_stb = 1'b0;
         if (inject && i == 4 * CPB + 7) begin
            i_tx_stb  = 1'b1;
            i_tx_data = 8'hFF;
         end
         if (inject && i == 4 * CPB + 8) i_tx_stb = 1'b0;
         if (o_uart_tx !== fr[i / CPB]) bad[i / CPB]++;
         if (o_tx_busy !== 1'b1) busy_lo++;
      end
      for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_bad_cycles", b), bad[b], 0);
      check("tx_busy_low_in_frame", busy_lo, 0);
      @(negedge i_clk);
      check("tx_busy_after_frame", int'(o_tx_busy), 0);
      check("tx_line_after_frame", int'(o_uart_tx), 1);
      if (inject) begin
         repeat (2 * CPB) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1 || o_tx_busy !== 1'b0) extra++;
         end
         check("tx_no_queued_frame", extra, 0);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      int         glitch;
      logic [7:0] exp;
   } rx_vec_t;

   rx_vec_t tbl[5];

   initial begin
      int s0, e0;
      tbl[0] = '{8'hA3, -1, 8'hA3};
      tbl[1] = '{8'h00, -1, 8'h00};
      tbl[2] = '{8'hFF, -1, 8'hFF};
      tbl[3] = '{8'h5A, -1, 8'h5A};
      tbl[4] = '{8'h00, GLITCH_IDX, GLITCH_EXP};

      i_reset   = 1'b1;
      i_uart_rx = 1'b1;
      i_tx_data = 8'h00;
      i_tx_stb  = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_uart_tx", int'(o_uart_tx), 1);
      check("rst_tx_busy", int'(o_tx_busy), 0);
      check("rst_rx_stb", int'(o_rx_stb), 0);
      check("rst_rx_frame_err", int'(o_rx_frame_err), 0);
      check("rst_rx_data", int'(o_rx_data), 0);
      i_reset = 1'b0;
      repeat (3) @(negedge i_clk);

      // TX 0x55 with an ignored strobe in the middle of the frame
      tx_frame(8'h55, 1'b1);

      for (int v = 0; v < 5; v++) rx_expect(tbl[v].d, tbl[v].glitch, tbl[v].exp);

      // 100-cycle low glitch on idle line, then a clean frame
      s0 = stb_cnt;
      e0 = err_cnt;
      @(negedge i_clk);
      i_uart_rx = 1'b0;
      repeat (100) @(negedge i_clk);
      i_uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge i_clk);
      check("glitch_no_stb", stb_cnt - s0, 0);
      check("glitch_no_err", err_cnt - e0, 0);
      rx_expect(8'h0F, -1, 8'h0F);

      // Framing error with the line held low, then recovery
      s0 = stb_cnt;
      e0 = err_cnt;
      rx_frame(8'h7E, 1'b0, -1, 2000);
      repeat (CPB) @(negedge i_clk);
      check("break_err_pulses", err_cnt - e0, 1);
      check("break_no_stb", stb_cnt - s0, 0);
      check("break_data_held", int'(o_rx_data), 8'h0F);
      rx_expect(8'h3C, -1, 8'h3C);

      // Reset in the middle of a TX frame (frame bit 4 = data bit 3 of 0xC3 = 0)
      @(negedge i_clk);
      i_tx_data = 8'hC3;
      i_tx_stb  = 1'b1;
      @(negedge i_clk);
      i_tx_stb = 1'b0;
      repeat (4 * CPB + H) @(negedge i_clk);
      check("pre_reset_line_low", int'(o_uart_tx), 0);
      i_reset = 1'b1;
      @(negedge i_clk);
      check("reset_mid_tx_line", int'(o_uart_tx), 1);
      check("reset_mid_tx_busy", int'(o_tx_busy), 0);
      i_reset = 1'b0;
      tx_frame(8'h81, 1'b0);

      check("stb_err_overlap", both_cnt, 0);
      check("pulse_wider_than_one", wide_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
